max_unpooling: RTL and testbench

- Streaming 2x2 unpooling / upsampling stage, the inverse of the 2x2 max/avg pooling stage in the CNN datapath.
- Consumes one pooled pixel per handshake, in row-major order, over an IMG_WIDTH x IMG_HEIGHT pooled map.
- Emits the 2*IMG_WIDTH x 2*IMG_HEIGHT map, also row-major.
- Two modes: nearest-neighbour replicate (avg-pool inverse) and max-unpool, where the value goes to the quadrant given by its recorded argmax index and the other three positions are zero.

---
 rtl/cnn_pool_pkg.sv | 21 ++
 rtl/unpool_line_buffer.sv | 23 ++
 rtl/max_unpooling.sv | 113 +++++++++++
 tb/tb_max_unpooling.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pool_pkg.sv
// Shared types for the CNN pooling/unpooling datapath stages.
package cnn_pool_pkg;

  typedef enum logic {
    UNPOOL_REPL = 1'b0,
    UNPOOL_MAX  = 1'b1
  } unpool_mode_e;

  typedef enum logic [1:0] {
    Q_TL = 2'd0,
    Q_TR = 2'd1,
    Q_BL = 2'd2,
    Q_BR = 2'd3
  } quad_e;

  typedef enum logic {
    S_TOP = 1'b0,
    S_BOT = 1'b1
  } unpool_state_e;

endpackage

// File: rtl/unpool_line_buffer.sv
// One pooled row of {data, idx} entries, replayed while the bottom output row is emitted.
module unpool_line_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/max_unpooling.sv
// Streaming 2x2 unpooling: each pooled pixel becomes two beats on the top output row, and is
// replayed from the line buffer as two beats on the bottom row.
module max_unpooling
  import cnn_pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 4,
  parameter int unsigned IMG_HEIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_idx,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned EW = DATA_WIDTH + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  unpool_state_e r_state;
  unpool_mode_e  r_mode;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_phase;
  logic          r_hold_vld;
  logic          r_rdy_en;
  logic [EW-1:0] r_hold;

  logic          w_col_end;
  logic          w_row_end;
  logic          w_in_fire;
  logic          w_out_fire;
  logic [CW-1:0] w_wr_col;
  logic [EW-1:0] w_buf_rd;
  logic [EW-1:0] w_entry;
  logic [1:0]    w_sel;

  assign w_col_end = (r_col == COL_LAST);
  assign w_row_end = (r_row == ROW_LAST);

  // r_rdy_en keeps in_ready low while reset is asserted.
  assign in_ready  = r_rdy_en && (r_state == S_TOP) &&
                     (!r_hold_vld || (r_phase && out_ready && !w_col_end));
  assign out_valid = (r_state == S_BOT) || r_hold_vld;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // A refill during the phase-1 drain belongs to the next column.
  assign w_wr_col = r_hold_vld ? r_col + 1'b1 : r_col;

  unpool_line_buffer #(
    .DEPTH(IMG_WIDTH),
    .WIDTH(EW),
    .AW   (CW)
  ) u_line_buf (
    .clk    (clk),
    .i_we   (w_in_fire),
    .i_waddr(w_wr_col),
    .i_wdata({in_data, in_idx}),
    .i_raddr(r_col),
    .o_rdata(w_buf_rd)
  );

  // Quadrant this beat represents: bit 1 = bottom row, bit 0 = right column.
  assign w_entry  = (r_state == S_TOP) ? r_hold : w_buf_rd;
  assign w_sel    = {r_state == S_BOT, r_phase};
  assign out_data = ((r_mode == UNPOOL_REPL) || (w_entry[1:0] == w_sel)) ?
                    w_entry[EW-1:2] : '0;
  assign out_last = (r_state == S_BOT) && w_col_end && r_phase && w_row_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_TOP;
      r_mode     <= UNPOOL_REPL;
      r_col      <= '0;
      r_row      <= '0;
      r_phase    <= 1'b0;
      r_hold_vld <= 1'b0;
      r_rdy_en   <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_out_fire) begin
        r_phase <= !r_phase;
        if (r_phase) begin
          r_col <= w_col_end ? '0 : r_col + 1'b1;
          if (r_state == S_TOP) begin
            r_hold_vld <= 1'b0;
            if (w_col_end) r_state <= S_BOT;
          end else if (w_col_end) begin
            r_state <= S_TOP;
            r_row   <= w_row_end ? '0 : r_row + 1'b1;
          end
        end
      end
      if (w_in_fire) begin
        r_hold_vld <= 1'b1;
        r_hold     <= {in_data, in_idx};
        if ((r_row == '0) && (w_wr_col == '0)) r_mode <= unpool_mode_e'(mode);
      end
    end
  end

endmodule

// File: tb/tb_max_unpooling.sv
// Scoreboard bench for max_unpooling on a 2x2 pooled map: directed frames are expanded into
// expected beats and a negedge monitor compares every accepted output beat in order.
module tb_max_unpooling;

  localparam int DW = 8;
  localparam int W  = 2;
  localparam int H  = 2;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_idx = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;

  always #5 clk = ~clk;

  max_unpooling #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_data  (in_data),
    .in_idx   (in_idx),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  // Expected beat: {bottom_row, last, data}
  logic [DW+1:0] exp_q[$];
  int            pop_cyc[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_pop = 0;
  int            cyc = 0;
  bit            bp_en = 1'b0;
  logic [DW-1:0] px_d [NPIX];
  logic [1:0]    px_i [NPIX];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Downstream ready: held high, or pseudo-random while backpressure is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output transfer.
  initial begin
    logic [DW+1:0] e;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_data", int'(out_data), int'(prev_data));
          check("stall_last", int'(out_last), int'(prev_last));
        end
        if (out_valid && exp_q.size() > 0 && exp_q[0][DW+1]) check("bot_in_ready", int'(in_ready), 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got data %0d, expected no beat", out_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", int'(out_data), int'(e[DW-1:0]));
            check("beat_last", int'(out_last), int'(e[DW]));
          end
          n_pop++;
          pop_cyc.push_back(cyc);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  // Expand the pooled frame in px_d/px_i into the expected 2W x 2H output beats.
  task automatic push_frame(input bit maxm);
    for (int r = 0; r < H; r++)
      for (int h = 0; h < 2; h++)
        for (int c = 0; c < W; c++)
          for (int p = 0; p < 2; p++) begin
            int            k;
            logic [DW-1:0] v;
            logic          last;
            k    = r * W + c;
            v    = (!maxm || int'(px_i[k]) == 2 * h + p) ? px_d[k] : '0;
            last = (r == H - 1) && (h == 1) && (c == W - 1) && (p == 1);
            exp_q.push_back({1'(h), last, v});
          end
  endtask

  task automatic send_pix(input logic [DW-1:0] d, input logic [1:0] ix, input logic m);
    int n;
    bit ok;
    n        = 0;
    in_data  = d;
    in_idx   = ix;
    mode     = m;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) break;
      n++;
      if (n > 400) begin
        n_err++;
        $display("FAIL in_ready_timeout: got no acceptance, expected one within 400 cycles");
        break;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit m0, input bit mr, input int gap);
    for (int k = 0; k < NPIX; k++) begin
      send_pix(px_d[k], px_i[k], (k == 0) ? m0 : mr);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        if (k % W == 0) begin
          @(negedge clk);
          check("gap_out_valid", int'(out_valid), 0);
          @(posedge clk);
        end
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_repl(input int b0, input int b1, input int b2, input int b3);
    px_d[0] = DW'(b0); px_d[1] = DW'(b1); px_d[2] = DW'(b2); px_d[3] = DW'(b3);
    px_i[0] = 2'd3;    px_i[1] = 2'd1;    px_i[2] = 2'd0;    px_i[3] = 2'd2;
  endtask

  task automatic load_max();
    px_d[0] = 8'd5; px_d[1] = 8'd7; px_d[2] = 8'd9; px_d[3] = 8'd11;
    px_i[0] = 2'd0; px_i[1] = 2'd3; px_i[2] = 2'd1; px_i[3] = 2'd2;
  endtask

  initial begin
    int base;
    int n;
    #200000;
    $display("FAIL watchdog: got no finish, expected one before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Replicate, full rate; 16 beats with one bubble between the two output row pairs.
    load_repl(10, 20, 30, 40);
    base = n_pop;
    push_frame(1'b0);
    send_frame(1'b0, 1'b0, 0);
    wait_drain();
    if (pop_cyc.size() >= base + 16) check("repl_span", pop_cyc[base+15] - pop_cyc[base], 16);
    else check("repl_pops", pop_cyc.size() - base, 16);

    // Max-unpool with a mid-frame mode change (ignored), then a replicate frame.
    load_max();
    push_frame(1'b1);
    send_frame(1'b1, 1'b0, 0);
    wait_drain();
    push_frame(1'b0);
    send_frame(1'b0, 1'b1, 0);
    wait_drain();

    // Backpressure on both modes.
    bp_en = 1'b1;
    load_repl(10, 20, 30, 40);
    push_frame(1'b0);
    send_frame(1'b0, 1'b0, 0);
    wait_drain();
    load_max();
    push_frame(1'b1);
    send_frame(1'b1, 1'b1, 0);
    wait_drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Input gaps of 3 cycles between pixels.
    load_repl(66, 77, 88, 99);
    push_frame(1'b0);
    send_frame(1'b0, 1'b0, 3);
    wait_drain();

    // Reset after 5 output beats, then a fresh frame.
    load_repl(9, 8, 7, 6);
    push_frame(1'b0);
    base = n_pop;
    send_pix(8'd9, 2'd0, 1'b0);
    send_pix(8'd8, 2'd0, 1'b0);
    n = 0;
    while (n_pop < base + 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("pre_reset_pops", n_pop - base, 5);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_repl(1, 2, 3, 4);
    push_frame(1'b0);
    send_frame(1'b0, 1'b0, 0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
